vram_writer: RTL

//  Host-side write port for the 2048x32 graphics VRAM, which the gfx engine reads.
//  - Accepts single-word writes over a valid/ready handshake and buffers them in a FIFO.
//  - Commits them to the VRAM write port, optionally only during vertical blanking,
//    so the scanline fetch never sees a partially updated frame.
//  - Sits between the CPU bus bridge and the VRAM RAM's write port.

---
 rtl/vram_writer.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/vram_writer.sv
// vram_writer: host-side write port for the 2048x32 graphics VRAM.
// Host commands are buffered in a FIFO and committed to the VRAM write port,
// optionally only while the scanline counter is in vertical blank.
// Optional feature: define VRAM_WRITER_FILL_EN to enable the FILL command
// (host_cmd_i = 1 writes host_len_i consecutive words starting at host_addr_i).
module vram_writer #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned GATE_VBLANK = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  video_vpos_i,
    input  logic        host_valid_i,
    output logic        host_ready_o,
    input  logic        host_cmd_i,
    input  logic [10:0] host_addr_i,
    input  logic [31:0] host_wdata_i,
    input  logic [3:0]  host_wmask_i,
    input  logic [10:0] host_len_i,
    output logic        vram_we_o,
    output logic [10:0] vram_addr_o,
    output logic [31:0] vram_wdata_o,
    output logic [3:0]  vram_wmask_o,
    output logic        busy_o
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);
    localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
`ifdef VRAM_WRITER_FILL_EN
    localparam logic [1:0] S_FILL  = 2'd2;
    localparam int unsigned EW     = 59;
`else
    localparam int unsigned EW     = 47;
`endif

    logic          win;
    logic [EW-1:0] din;
    logic [EW-1:0] head;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_next;
    logic          fifo_empty;
    logic          push;
    logic          pop;

    logic [1:0]    state;
    logic [10:0]   cur_addr;
    logic [31:0]   cur_data;
    logic [3:0]    cur_mask;

    logic [10:0]   head_addr;
    logic [31:0]   head_data;
    logic [3:0]    head_mask;

`ifdef VRAM_WRITER_FILL_EN
    logic          head_cmd;
    logic [10:0]   head_len;
    logic [10:0]   cnt;

    assign din      = {host_cmd_i, host_len_i, host_wmask_i, host_wdata_i, host_addr_i};
    assign head_cmd = head[58];
    assign head_len = head[57:47];
`else
    logic          unused_cmd_len;

    assign din            = {host_wmask_i, host_wdata_i, host_addr_i};
    assign unused_cmd_len = ^{host_cmd_i, host_len_i};
`endif

    assign head      = mem[rd_ptr];
    assign head_mask = head[46:43];
    assign head_data = head[42:11];
    assign head_addr = head[10:0];

    assign win        = (GATE_VBLANK == 0) || (video_vpos_i >= V_ACT);
    assign fifo_empty = (count == '0);
    assign push       = host_valid_i && host_ready_o;
    // IDLE and WRITE both pop, so a WRITE's output cycle overlaps the next pop
    assign pop        = !fifo_empty && win && ((state == S_IDLE) || (state == S_WRITE));
    assign busy_o     = !fifo_empty || (state != S_IDLE) || vram_we_o;

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + (AW + 1)'(1);
        end else if (!push && pop) begin
            count_next = count - (AW + 1)'(1);
        end
    end

    // FIFO storage array (no reset needed; contents qualified by count)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    // FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            host_ready_o <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count        <= count_next;
            host_ready_o <= (count_next != DEPTH_C);
        end
    end

    // Commit FSM and registered VRAM write port
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cur_addr     <= '0;
            cur_data     <= '0;
            cur_mask     <= '0;
            vram_we_o    <= 1'b0;
            vram_addr_o  <= '0;
            vram_wdata_o <= '0;
            vram_wmask_o <= '0;
`ifdef VRAM_WRITER_FILL_EN
            cnt          <= '0;
`endif
        end else begin
            vram_we_o <= 1'b0;
            case (state)
                S_IDLE, S_WRITE: begin
                    if (state == S_WRITE) begin
                        vram_we_o    <= 1'b1;
                        vram_addr_o  <= cur_addr;
                        vram_wdata_o <= cur_data;
                        vram_wmask_o <= cur_mask;
                    end
                    if (pop) begin
                        cur_addr <= head_addr;
                        cur_data <= head_data;
                        cur_mask <= head_mask;
                        state    <= S_WRITE;
`ifdef VRAM_WRITER_FILL_EN
                        if (head_cmd) begin
                            state <= S_FILL;
                            cnt   <= head_len;
                        end
`endif
                    end else begin
                        state <= S_IDLE;
                    end
                end
`ifdef VRAM_WRITER_FILL_EN
                S_FILL: begin
                    // cur_addr doubles as the fill pointer; it wraps at 11 bits
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else if (win) begin
                        vram_we_o    <= 1'b1;
                        vram_addr_o  <= cur_addr;
                        vram_wdata_o <= cur_data;
                        vram_wmask_o <= cur_mask;
                        cur_addr     <= cur_addr + 11'd1;
                        cnt          <= cnt - 11'd1;
                        if (cnt == 11'd1) begin
                            state <= S_IDLE;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
